// File: rtl/rt_alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rt_alu_vec_pipe
//  Description : Two-stage signed fixed-point vector ALU (add/sub/mul/dot/scale)
//                with saturating or wrapping results and valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module rt_alu_vec_pipe #(
    parameter int WORD_LEN = 32,
    parameter int IW       = 16,
    parameter int QW       = 16,
    parameter int LANES    = 3,
    parameter int OP_LEN   = 4,
    parameter bit SAT      = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [OP_LEN-1:0]               op,
    input  logic [LANES-1:0][WORD_LEN-1:0]  a,
    input  logic [LANES-1:0][WORD_LEN-1:0]  b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES-1:0][WORD_LEN-1:0]  out,
    output logic [LANES-1:0]                out_ovf
);

    localparam int c_PW = 2 * WORD_LEN;
    localparam int c_XW = c_PW + $clog2(LANES) + 1;

    localparam logic [OP_LEN-1:0] c_OP_ADD = OP_LEN'(0);
    localparam logic [OP_LEN-1:0] c_OP_SUB = OP_LEN'(1);
    localparam logic [OP_LEN-1:0] c_OP_MUL = OP_LEN'(2);
    localparam logic [OP_LEN-1:0] c_OP_DOT = OP_LEN'(3);
    localparam logic [OP_LEN-1:0] c_OP_SCL = OP_LEN'(4);

    generate
        if (WORD_LEN != IW + QW || LANES < 1) begin : g_bad_cfg
            $error("rt_alu_vec_pipe: WORD_LEN must equal IW+QW and LANES must be >= 1");
        end
    endgenerate

    function automatic logic signed [WORD_LEN:0] ext_w1(input logic [WORD_LEN-1:0] x);
        return {x[WORD_LEN-1], x};
    endfunction

    function automatic logic signed [c_PW-1:0] ext_p(input logic [WORD_LEN-1:0] x);
        return {{WORD_LEN{x[WORD_LEN-1]}}, x};
    endfunction

    function automatic logic signed [c_XW-1:0] ext_xp(input logic [c_PW-1:0] x);
        return {{(c_XW-c_PW){x[c_PW-1]}}, x};
    endfunction

    function automatic logic signed [c_XW-1:0] ext_xs(input logic [WORD_LEN:0] x);
        return {{(c_XW-WORD_LEN-1){x[WORD_LEN]}}, x};
    endfunction

    logic                           w_adv;
    logic                           w_accept;
    logic signed [WORD_LEN:0]       w_addsub [LANES];
    logic signed [c_PW-1:0]         w_prod   [LANES];

    logic                           r_s1_valid;
    logic [OP_LEN-1:0]              r_s1_op;
    logic signed [WORD_LEN:0]       r_s1_addsub [LANES];
    logic signed [c_PW-1:0]         r_s1_prod   [LANES];

    logic signed [c_XW-1:0]         w_dot;
    logic signed [c_XW-1:0]         w_exact;
    logic [LANES-1:0][WORD_LEN-1:0] w_res;
    logic [LANES-1:0]               w_ovf;

    logic                           r_out_valid;
    logic [LANES-1:0][WORD_LEN-1:0] r_out;
    logic [LANES-1:0]               r_out_ovf;

    // Both stages move together; an empty S1 still waits on a stalled S2.
    assign w_adv    = ~r_out_valid | out_ready;
    assign w_accept = in_valid & w_adv;
    assign in_ready = w_adv;

    // Non-arithmetic opcodes carry operand A through the add/sub path.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_addsub[i] = ext_w1(a[i]);
            if (op == c_OP_ADD) begin
                w_addsub[i] = ext_w1(a[i]) + ext_w1(b[i]);
            end else if (op == c_OP_SUB) begin
                w_addsub[i] = ext_w1(a[i]) - ext_w1(b[i]);
            end
            w_prod[i] = ext_p(a[i]) * ((op == c_OP_SCL) ? ext_p(b[0]) : ext_p(b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_op <= op;
            for (int i = 0; i < LANES; i++) begin
                r_s1_addsub[i] <= w_addsub[i];
                r_s1_prod[i]   <= w_prod[i];
            end
        end
    end

    always_comb begin
        w_dot   = '0;
        w_exact = '0;
        w_res   = '0;
        w_ovf   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dot = w_dot + ext_xp(r_s1_prod[i]);
        end
        w_dot = w_dot >>> QW;
        for (int i = 0; i < LANES; i++) begin
            case (r_s1_op)
                c_OP_MUL, c_OP_SCL: w_exact = ext_xp(r_s1_prod[i]) >>> QW;
                c_OP_DOT:           w_exact = (i == 0) ? w_dot : '0;
                default:            w_exact = ext_xs(r_s1_addsub[i]);
            endcase
            // In range iff every bit above the result's sign bit matches it.
            w_ovf[i] = !((w_exact[c_XW-1:WORD_LEN-1] == '0) ||
                         (w_exact[c_XW-1:WORD_LEN-1] == '1));
            w_res[i] = w_exact[WORD_LEN-1:0];
            if (w_ovf[i] && SAT) begin
                w_res[i] = w_exact[c_XW-1] ? {1'b1, {(WORD_LEN-1){1'b0}}}
                                           : {1'b0, {(WORD_LEN-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_ovf   <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= w_accept;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out     <= w_res;
                r_out_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rt_alu_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rt_alu_vec_pipe
//  Description : Self-checking bench for rt_alu_vec_pipe (Q16.16, 3 lanes,
//                saturating and wrapping instances side by side).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rt_alu_vec_pipe;

    localparam int W   = 32;
    localparam int QW  = 16;
    localparam int L   = 3;
    localparam int OPL = 4;

    typedef logic [L-1:0][W-1:0] vec_t;
    typedef struct packed {
        vec_t           r;
        logic [L-1:0]   v;
    } res_t;

    localparam logic signed [127:0] c_MAXV = 128'sh7FFFFFFF;
    localparam logic signed [127:0] c_MINV = -128'sh80000000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           out_ready;
    logic [OPL-1:0] op;
    vec_t           a, b;
    logic           in_ready, out_valid, in_ready_w, out_valid_w;
    vec_t           out, out_w;
    logic [L-1:0]   ovf, ovf_w;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;

    res_t exp_s[$];
    res_t exp_w[$];

    always #5 clk = ~clk;

    rt_alu_vec_pipe #(.WORD_LEN(W), .IW(16), .QW(QW), .LANES(L), .OP_LEN(OPL), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(ovf)
    );

    rt_alu_vec_pipe #(.WORD_LEN(W), .IW(16), .QW(QW), .LANES(L), .OP_LEN(OPL), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op(op),
        .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w), .out_ovf(ovf_w)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Exact arithmetic at 128 bits, then range-check against the 32-bit result.
    function automatic res_t model(input logic [3:0] o, input vec_t x, input vec_t y, input bit sat);
        res_t res;
        logic signed [127:0] acc, xi, yi, ex;
        acc = 128'sd0;
        for (int i = 0; i < L; i++) begin
            acc = acc + 128'($signed(x[i])) * 128'($signed(y[i]));
        end
        for (int i = 0; i < L; i++) begin
            xi = 128'($signed(x[i]));
            yi = 128'($signed(y[i]));
            case (o)
                4'd0:    ex = xi + yi;
                4'd1:    ex = xi - yi;
                4'd2:    ex = (xi * yi) >>> QW;
                4'd3:    ex = (i == 0) ? (acc >>> QW) : 128'sd0;
                4'd4:    ex = (xi * 128'($signed(y[0]))) >>> QW;
                default: ex = xi;
            endcase
            res.v[i] = (ex > c_MAXV) || (ex < c_MINV);
            res.r[i] = ex[W-1:0];
            if (res.v[i] && sat) res.r[i] = (ex < 128'sd0) ? 32'h80000000 : 32'h7FFFFFFF;
        end
        return res;
    endfunction

    function automatic logic [31:0] rword();
        logic [31:0] t;
        t = $urandom;
        case ($urandom % 5)
            0: return t;
            1: return {{12{t[19]}}, t[19:0]};
            2: return {{8{t[23]}}, t[23:0]};
            3: begin
                case (t % 5)
                    0: return 32'h80000000;
                    1: return 32'h7FFFFFFF;
                    2: return 32'h7FFF0000;
                    3: return 32'hFFFF0000;
                    default: return 32'h00010000;
                endcase
            end
            default: return {{15{t[16]}}, t[16:0]};
        endcase
    endfunction

    // Scoreboard and protocol checks, sampled mid-cycle.
    logic         hold_q = 1'b0;
    vec_t         hold_o, hold_ow;
    logic [L-1:0] hold_v, hold_vw;
    res_t         e, ew;

    always @(negedge clk) begin
        if (rst) begin
            exp_s.delete();
            exp_w.delete();
            hold_q = 1'b0;
        end else begin
            chk("in_ready_rule", 128'(in_ready), 128'(!out_valid || out_ready));
            chk("wrap_inst_valid", 128'(out_valid_w), 128'(out_valid));
            chk("wrap_inst_ready", 128'(in_ready_w), 128'(in_ready));
            if (hold_q) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_out", 128'(out), 128'(hold_o));
                chk("hold_ovf", 128'(ovf), 128'(hold_v));
                chk("hold_out_wrap", 128'(out_w), 128'(hold_ow));
                chk("hold_ovf_wrap", 128'(ovf_w), 128'(hold_vw));
            end
            if (out_valid && out_ready) begin
                if (exp_s.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result actual=out_valid with out=%0h required=no pending op", out);
                end else begin
                    e  = exp_s.pop_front();
                    ew = exp_w.pop_front();
                    n_pop++;
                    chk("result_out", 128'(out), 128'(e.r));
                    chk("result_ovf", 128'(ovf), 128'(e.v));
                    chk("result_out_wrap", 128'(out_w), 128'(ew.r));
                    chk("result_ovf_wrap", 128'(ovf_w), 128'(ew.v));
                end
            end
            hold_q  = out_valid && !out_ready;
            hold_o  = out;
            hold_v  = ovf;
            hold_ow = out_w;
            hold_vw = ovf_w;
            if (in_valid && in_ready) begin
                exp_s.push_back(model(op, a, b, 1'b1));
                exp_w.push_back(model(op, a, b, 1'b0));
            end
        end
    end

    task automatic send(input logic [3:0] o, input vec_t x, input vec_t y);
        int n;
        n = 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready low for %0d cycles required=accept", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_lit(input string nm, input logic [3:0] o, input vec_t x, input vec_t y,
                           input vec_t eo, input logic [L-1:0] ev, input vec_t eow, input logic [L-1:0] evw);
        send(o, x, y);
        chk({nm, "_lat1"}, 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        chk({nm, "_lat2"}, 128'(out_valid), 128'(1));
        chk({nm, "_out"}, 128'(out), 128'(eo));
        chk({nm, "_ovf"}, 128'(ovf), 128'(ev));
        chk({nm, "_out_wrap"}, 128'(out_w), 128'(eow));
        chk({nm, "_ovf_wrap"}, 128'(ovf_w), 128'(evw));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t va, vb, vo;
        res_t m;
        int   base;
        bit   rand_done;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out", 128'(out), 128'(0));
        chk("reset_ovf", 128'(ovf), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));

        // Model pinned against hand-worked values.
        va = {32'h7FFF0000, 32'hFFFE8000, 32'h00018000};
        vb = {3{32'h00020000}};
        m = model(4'd2, va, vb, 1'b1);
        chk("model_mul_out", 128'(m.r), 128'({32'h7FFFFFFF, 32'hFFFD0000, 32'h00030000}));
        chk("model_mul_ovf", 128'(m.v), 128'(3'b100));
        va = {32'h0, 32'h0, 32'h80000000};
        vb = {32'h0, 32'h0, 32'h00010000};
        m = model(4'd1, va, vb, 1'b0);
        chk("model_sub_wrap", 128'(m.r), 128'({32'h0, 32'h0, 32'h7FFF0000}));
        m = model(4'd3, {32'h00030000, 32'h00020000, 32'h00010000},
                        {32'h00060000, 32'h00050000, 32'h00040000}, 1'b1);
        chk("model_dot", 128'(m.r), 128'({32'h0, 32'h0, 32'h00200000}));

        // Directed vectors with literal expectations and 2-cycle latency.
        va = {32'hFFFF0000, 32'h00020000, 32'h00010000};
        vb = {3{32'h00008000}};
        vo = {32'hFFFF8000, 32'h00028000, 32'h00018000};
        run_lit("add", 4'd0, va, vb, vo, 3'b000, vo, 3'b000);
        va = {32'h7FFF0000, 32'hFFFE8000, 32'h00018000};
        vb = {3{32'h00020000}};
        run_lit("mul", 4'd2, va, vb, {32'h7FFFFFFF, 32'hFFFD0000, 32'h00030000}, 3'b100,
                {32'hFFFE0000, 32'hFFFD0000, 32'h00030000}, 3'b100);
        va = {32'h00030000, 32'h00020000, 32'h00010000};
        vb = {32'h00060000, 32'h00050000, 32'h00040000};
        run_lit("dot", 4'd3, va, vb, {32'h0, 32'h0, 32'h00200000}, 3'b000,
                {32'h0, 32'h0, 32'h00200000}, 3'b000);
        va = {32'h0, 32'h0, 32'h80000000};
        vb = {32'h0, 32'h0, 32'h00010000};
        run_lit("sub", 4'd1, va, vb, {32'h0, 32'h0, 32'h80000000}, 3'b001,
                {32'h0, 32'h0, 32'h7FFF0000}, 3'b001);
        va = {32'h00050000, 32'hFFFF0000, 32'h00020000};
        vb = {32'h0, 32'h0, 32'hFFFF8000};
        run_lit("scl", 4'd4, va, vb, {32'hFFFD8000, 32'h00008000, 32'hFFFF0000}, 3'b000,
                {32'hFFFD8000, 32'h00008000, 32'hFFFF0000}, 3'b000);

        // Back-to-back ops into a stalled consumer.
        base = n_pop;
        out_ready = 1'b0;
        fork
            begin
                send(4'd0, {32'hFFFF0000, 32'h00020000, 32'h00010000}, {3{32'h00008000}});
                send(4'd2, {32'h7FFF0000, 32'hFFFE8000, 32'h00018000}, {3{32'h00020000}});
                send(4'd3, {32'h00030000, 32'h00020000, 32'h00010000},
                           {32'h00060000, 32'h00050000, 32'h00040000});
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_in_ready", 128'(in_ready), 128'(0));
                chk("stall_out_valid", 128'(out_valid), 128'(1));
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("stall_results", 128'(n_pop - base), 128'(3));
        chk("stall_drained", 128'(exp_s.size()), 128'(0));

        // Reset with two operations in flight, one already presented.
        out_ready = 1'b0;
        send(4'd0, {3{32'h00010000}}, {3{32'h00010000}});
        send(4'd1, {3{32'h00030000}}, {3{32'h00010000}});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out", 128'(out), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_stale", 128'(out_valid), 128'(0));

        // Randomized traffic with random back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 400; t++) begin
                    logic [3:0] ro;
                    vec_t rx, ry;
                    repeat ($urandom % 3) begin
                        @(posedge clk);
                        #1;
                    end
                    ro = (($urandom % 8) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                    for (int i = 0; i < L; i++) begin
                        rx[i] = rword();
                        ry[i] = rword();
                    end
                    send(ro, rx, ry);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = (($urandom % 4) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("random_drained", 128'(exp_s.size()), 128'(0));
        chk("random_idle", 128'(out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
